// File: rtl/fpu_result_packer.sv
// Normalizes, rounds (nearest-even) and packs an unpacked FPU result into
// the 32-bit word {sign, exp[9:0], frac[20:0]}, with zero/overflow/underflow/inexact flags.
module fpu_result_packer #(
    parameter int EXP_W  = 10,
    parameter int FRAC_W = 21,
    parameter int BIAS   = 511
) (
    input  logic                clock_100Khz,
    input  logic                reset,
    input  logic                start,
    input  logic                sign_in,
    input  logic [EXP_W+1:0]    exp_in,
    input  logic [FRAC_W+3:0]   mant_in,
    output logic                busy,
    output logic                done,
    output logic [31:0]         data_out,
    output logic [3:0]          status_out,
    output logic [1:0]          o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_PACK} state_t;

    localparam int EXP_MAX_I = 2 * BIAS + 1;
    localparam logic signed [EXP_W+1:0] EXP_MAX = EXP_MAX_I[EXP_W+1:0];
    localparam logic signed [EXP_W+1:0] EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};
    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
    localparam int MW = FRAC_W + 4;

    state_t                   r_state, w_state_nxt;
    logic                     r_sign, w_sign_nxt;
    logic signed [EXP_W+1:0]  r_exp, w_exp_nxt;
    logic [MW-1:0]            r_mant, w_mant_nxt;
    logic                     r_zero, w_zero_nxt;
    logic                     r_inexact, w_inexact_nxt;
    logic                     r_busy, w_busy_nxt;
    logic                     r_done, w_done_nxt;
    logic [31:0]              r_data, w_data_nxt;
    logic [3:0]               r_status, w_status_nxt;
    logic                     w_inc;
    logic [FRAC_W:0]          w_frac_sum;

    assign busy        = r_busy;
    assign done        = r_done;
    assign data_out    = r_data;
    assign status_out  = r_status;
    assign o_dbg_state = r_state;

    // Guard rounds up on a tie only when the retained LSB is odd.
    assign w_inc      = r_mant[1] & (r_mant[0] | r_mant[2]);
    assign w_frac_sum = {1'b0, r_mant[FRAC_W+1:2]} + {{FRAC_W{1'b0}}, w_inc};

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mant    <= '0;
            r_zero    <= 1'b0;
            r_inexact <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_data    <= '0;
            r_status  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sign    <= w_sign_nxt;
            r_exp     <= w_exp_nxt;
            r_mant    <= w_mant_nxt;
            r_zero    <= w_zero_nxt;
            r_inexact <= w_inexact_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_data    <= w_data_nxt;
            r_status  <= w_status_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sign_nxt    = r_sign;
        w_exp_nxt     = r_exp;
        w_mant_nxt    = r_mant;
        w_zero_nxt    = r_zero;
        w_inexact_nxt = r_inexact;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_data_nxt    = r_data;
        w_status_nxt  = r_status;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sign_nxt    = sign_in;
                    w_exp_nxt     = exp_in;
                    w_mant_nxt    = mant_in;
                    w_zero_nxt    = 1'b0;
                    w_inexact_nxt = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_NORM;
                end
            end
            S_NORM: begin
                if (r_mant == '0) begin
                    w_zero_nxt  = 1'b1;
                    w_state_nxt = S_PACK;
                end else if (r_mant[MW-1]) begin
                    // Bit shifted out of the bottom folds into sticky.
                    w_mant_nxt = {1'b0, r_mant[MW-1:2], r_mant[1] | r_mant[0]};
                    w_exp_nxt  = r_exp + EXP_ONE;
                end else if (!r_mant[MW-2]) begin
                    w_mant_nxt = {r_mant[MW-2:0], 1'b0};
                    w_exp_nxt  = r_exp - EXP_ONE;
                end else begin
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                w_inexact_nxt = r_mant[1] | r_mant[0];
                w_mant_nxt    = {2'b01, w_frac_sum[FRAC_W-1:0], 2'b00};
                if (w_frac_sum[FRAC_W]) begin
                    w_exp_nxt = r_exp + EXP_ONE;
                end
                w_state_nxt = S_PACK;
            end
            S_PACK: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
                if (r_zero) begin
                    w_data_nxt   = {r_sign, 31'h0};
                    w_status_nxt = 4'b0001;
                end else if (r_exp >= EXP_MAX) begin
                    w_data_nxt   = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    w_status_nxt = 4'b1010;
                end else if (r_exp <= EXP_ZERO) begin
                    w_data_nxt   = {r_sign, 31'h0};
                    w_status_nxt = 4'b1101;
                end else begin
                    w_data_nxt   = {r_sign, r_exp[EXP_W-1:0], r_mant[FRAC_W+1:2]};
                    w_status_nxt = {r_inexact, 3'b000};
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fpu_result_packer.sv
// Directed bench for fpu_result_packer: a driver issues operations and queues the
// expected word/flags and done cycle; a monitor checks every done pulse against them.
module tb_fpu_result_packer;
    logic        clock_100Khz;
    logic        reset;
    logic        start;
    logic        sign_in;
    logic [11:0] exp_in;
    logic [24:0] mant_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic [1:0]  o_dbg_state;

    logic [35:0] exp_q[$];
    int          lat_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;

    fpu_result_packer dut (
        .clock_100Khz(clock_100Khz),
        .reset(reset),
        .start(start),
        .sign_in(sign_in),
        .exp_in(exp_in),
        .mant_in(mant_in),
        .busy(busy),
        .done(done),
        .data_out(data_out),
        .status_out(status_out),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clock_100Khz = 1'b0;
    always #5000 clock_100Khz = ~clock_100Khz;
    always @(posedge clock_100Khz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clock_100Khz) begin
        if (reset === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got data %h status %h with nothing pending", data_out, status_out);
            end else begin
                logic [35:0] e;
                int          lc;
                e  = exp_q.pop_front();
                lc = lat_q.pop_front();
                check("result", {data_out, status_out}, e);
                check("latency", 36'(cyc), 36'(lc));
            end
        end
    end

    // driver: one operation, optionally hammering start while busy
    task automatic run_op(input logic s, input logic [11:0] e, input logic [24:0] m,
                          input logic [31:0] xd, input logic [3:0] xs, input int lat,
                          input bit hammer);
        int got;
        @(negedge clock_100Khz);
        exp_q.push_back({xd, xs});
        lat_q.push_back(cyc + 1 + lat);
        sign_in = s;
        exp_in  = e;
        mant_in = m;
        start   = 1'b1;
        got     = done_cnt;
        for (int k = 1; k <= lat + 8; k++) begin
            @(negedge clock_100Khz);
            if (hammer && k < lat && (k % 2) == 1) begin
                start   = 1'b1;
                sign_in = ~s;
                exp_in  = 12'd700;
                mant_in = 25'h1555555;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done_cnt != got) break;
        end
        start = 1'b0;
        if (done_cnt == got) begin
            total++;
            bad++;
            $display("FAIL timeout: no done within %0d cycles for exp %0d mant %h", lat + 8, e, m);
            exp_q.delete();
            lat_q.delete();
        end
        repeat (3) @(negedge clock_100Khz);
        check("hold", {data_out, status_out}, {xd, xs});
        check("idle_busy", {35'h0, busy}, 36'h0);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        sign_in = 1'b0;
        exp_in  = '0;
        mant_in = '0;
        repeat (3) @(negedge clock_100Khz);
        check("reset_out", {busy, done, data_out, status_out}, 38'h0);
        reset = 1'b1;

        run_op(1'b0, 12'd511,  25'h0800000, 32'h3FE00000, 4'b0000, 3,  1'b0);
        run_op(1'b0, 12'd513,  25'h0200000, 32'h3FE00000, 4'b0000, 5,  1'b0);
        run_op(1'b0, 12'd511,  25'h1000000, 32'h40000000, 4'b0000, 4,  1'b0);
        run_op(1'b1, 12'd511,  25'h0FFFFFE, 32'hC0000000, 4'b1000, 3,  1'b0);
        run_op(1'b0, 12'd1023, 25'h0800000, 32'h7FE00000, 4'b1010, 3,  1'b0);
        run_op(1'b0, 12'd0,    25'h0800000, 32'h00000000, 4'b1101, 3,  1'b0);
        run_op(1'b1, 12'd100,  25'h0000000, 32'h80000000, 4'b0001, 2,  1'b0);
        run_op(1'b0, 12'd1022, 25'h1000000, 32'h7FE00000, 4'b1010, 4,  1'b0);
        run_op(1'b0, 12'd1,    25'h0400000, 32'h00000000, 4'b1101, 4,  1'b0);
        run_op(1'b0, 12'd511,  25'h0800002, 32'h3FE00000, 4'b1000, 3,  1'b0);
        run_op(1'b0, 12'd511,  25'h0800006, 32'h3FE00002, 4'b1000, 3,  1'b0);
        run_op(1'b0, 12'd511,  25'h1000003, 32'h40000000, 4'b1000, 4,  1'b0);
        run_op(1'b1, 12'd300,  25'h0ABCDEC, 32'hA58AF37B, 4'b0000, 3,  1'b0);
        run_op(1'b0, 12'd600,  25'h0000001, 32'h48200000, 4'b0000, 26, 1'b0);
        run_op(1'b0, 12'd513,  25'h0200000, 32'h3FE00000, 4'b0000, 5,  1'b1);

        // reset in the middle of normalization
        @(negedge clock_100Khz);
        sign_in = 1'b1;
        exp_in  = 12'd600;
        mant_in = 25'h0000001;
        start   = 1'b1;
        @(negedge clock_100Khz);
        start = 1'b0;
        repeat (5) @(negedge clock_100Khz);
        #2000;
        reset = 1'b0;
        #10;
        check("mid_reset", {o_dbg_state, busy, done, data_out, status_out}, 40'h0);
        repeat (2) @(negedge clock_100Khz);
        reset = 1'b1;
        run_op(1'b0, 12'd511, 25'h1000000, 32'h40000000, 4'b0000, 4, 1'b0);

        repeat (2) @(negedge clock_100Khz);
        check("queue_empty", 36'(exp_q.size()), 36'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
